// File: rtl/cla_multibyte_sequencer.sv
// cla_multibyte_sequencer
// Chains an external combinational 8-bit carry-lookahead adder into an
// NBYTES-wide add/subtract engine. Operand byte pairs arrive LSB-first on a
// valid/ready stream; result bytes leave on a one-deep registered
// valid/ready stream. The MSB byte carries the final carry and signed-overflow flags.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clr                   synchronous abort of partial operation and output register
//   in_valid/in_ready     operand byte-pair handshake (in_a, in_b, op_sub)
//   add_a/add_b/add_cin   drive to the external adder
//   add_sum/add_cout      result from the external adder
//   out_valid/out_ready   result byte handshake (out_sum, out_last, out_carry, out_ovf)
//   busy                  partial operation in progress
`timescale 1ns/1ps

module cla_multibyte_sequencer #(
   parameter int unsigned NBYTES = 4,
   parameter int unsigned IDXW   = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_a,
   input  logic [7:0] in_b,
   input  logic       op_sub,
   output logic [7:0] add_a,
   output logic [7:0] add_b,
   output logic       add_cin,
   input  logic [7:0] add_sum,
   input  logic       add_cout,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_sum,
   output logic       out_last,
   output logic       out_carry,
   output logic       out_ovf,
   output logic       busy
);

   localparam int unsigned   BW       = 8;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

   logic [IDXW-1:0] idx_q, idx_d;
   logic            carry_q, carry_d;
   logic            sub_q, sub_d;
   logic            out_valid_q, out_valid_d;
   logic [BW-1:0]   out_sum_q, out_sum_d;
   logic            out_last_q, out_last_d;
   logic            out_carry_q, out_carry_d;
   logic            out_ovf_q, out_ovf_d;

   logic            first_byte;
   logic            sub_eff;
   logic            acc;

   // Adder drive and input handshake; byte 0 takes its subtract mode live
   // from op_sub, later bytes from the latched copy.
   always_comb begin
      first_byte = (idx_q == '0);
      sub_eff    = first_byte ? op_sub : sub_q;
      add_a      = in_a;
      add_b      = in_b ^ {BW{sub_eff}};
      add_cin    = first_byte ? sub_eff : carry_q;
      in_ready   = ~clr & (~out_valid_q | out_ready);
      acc        = in_valid & in_ready;
   end

   // Byte-index state register and output pipeline register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= '0;
         carry_q     <= 1'b0;
         sub_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_last_q  <= 1'b0;
         out_carry_q <= 1'b0;
         out_ovf_q   <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         sub_q       <= sub_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_last_q  <= out_last_d;
         out_carry_q <= out_carry_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   // Next-state: clr aborts, an accept loads a new result byte (replacing any
   // byte drained in the same cycle), a drain alone empties the register.
   always_comb begin
      idx_d       = idx_q;
      carry_d     = carry_q;
      sub_d       = sub_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_last_d  = out_last_q;
      out_carry_d = out_carry_q;
      out_ovf_d   = out_ovf_q;

      if (clr) begin
         idx_d       = '0;
         carry_d     = 1'b0;
         sub_d       = 1'b0;
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
         out_carry_d = 1'b0;
         out_ovf_d   = 1'b0;
      end else if (acc) begin
         out_sum_d   = add_sum;
         out_valid_d = 1'b1;
         carry_d     = add_cout;
         if (first_byte) begin
            sub_d = op_sub;
         end
         if (idx_q == LAST_IDX) begin
            idx_d       = '0;
            carry_d     = 1'b0;
            out_last_d  = 1'b1;
            out_carry_d = add_cout;
            // Overflow: operand signs agree (B as seen by the adder) but sum sign differs.
            out_ovf_d   = (in_a[BW-1] == add_b[BW-1]) & (add_sum[BW-1] != in_a[BW-1]);
         end else begin
            idx_d       = idx_q + IDXW'(1);
            out_last_d  = 1'b0;
            out_carry_d = 1'b0;
            out_ovf_d   = 1'b0;
         end
      end else if (out_valid_q & out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_last  = out_last_q;
   assign out_carry = out_carry_q;
   assign out_ovf   = out_ovf_q;
   assign busy      = (idx_q != '0);

endmodule
